timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Programmable timer controller that sequences a prescaled event counter.
- The host starts and stops it, and selects period, prescale and mode (one-shot or periodic).
- Emits a 1-cycle tick each time the period elapses, and a done pulse when a one-shot run completes.
- Sits between control registers and the counter datapath; it is the only driver of the counter's enable and clear.

Parameters:
- W, 16, main counter width; period range 1..2^W-1.
- PW, 8, prescaler width; prescale ratio is presc+1.

Ports:
- clk  in  1  system clock.
- clrn  in  1  reset; synchronous, active-low.
- start  in  1  start/restart request; sampled each cycle.
- stop  in  1  abort request.
- mode  in  1  0 = one-shot, 1 = periodic; latched on accepted start.
- period  in  W  event count per tick; latched on accepted start.
- presc  in  PW  prescale value; latched on accepted start.
- busy  out  1  high while state = RUN.
- tick  out  1  1-cycle pulse, period elapsed.
- done  out  1  1-cycle pulse, one-shot complete.
- err  out  1  1-cycle pulse, start rejected because period = 0.
- count  out  W  current main counter value.

Behaviour:
- Reset (clrn = 0 at a clk edge): state IDLE; latched mode/period/presc = 0; prescaler p = 0; count = 0; busy/tick/done/err = 0.
- Reset has priority over all other inputs.
- Reset mid-RUN aborts without any tick/done.

States:
- IDLE: counters held at 0.
- RUN: counting.

Cycle numbering and latency (start high in cycle 0):
- Cycle 1: state = RUN, busy = 1, p = 0, count = 0.
- en is combinational: en = RUN && (p == presc_l).
- p wraps to 0 on en, otherwise increments.
- count increments on en.
- Terminal = en && (count == period_l-1). At terminal, count clears to 0.
- tick is registered: high in the cycle after terminal. First tick is in cycle (presc+1)*period+1.
- Periodic: a tick every (presc+1)*period cycles thereafter.
- One-shot: at the terminal edge state -> IDLE. tick and done are both high in the same cycle; busy is already 0 in that cycle.

Priority within a cycle:
- stop > start > terminal.
- stop in RUN: -> IDLE; p and count cleared; no tick/done even if terminal coincides.
- stop in IDLE: no effect.
- start in RUN (restart): reload mode/period/presc; clear p and count; stay in RUN; suppress a coincident terminal (no tick).
- start with period = 0: rejected. err pulses the next cycle, state and latched values are unchanged, and a run in progress continues.

Boundaries and widths:
- period = 1 with presc = 0: terminal every cycle; tick is continuously high in periodic mode.
- count never exceeds period_l-1.
- p never exceeds presc_l.
- All arithmetic is unsigned. Wrap is explicit at terminal only; no natural overflow is possible.
- Inputs other than start/stop are ignored outside the start cycle.

Decomposition:
- Package timer_pkg holds:
  - typedef enum logic [0:0] {IDLE, RUN} state_t;
  - localparam MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- Main counter: instantiate the existing Counter module (width W).
  - en = en.
  - Its synchronous active-low clear is driven by ~(~clrn | stop_acc | start_acc | terminal | IDLE).
  - Its asynchronous clear input is tied high.
- Prescaler: an inline register in timer_ctrl; no extra sub-module.

Test Plan:
- Reset, then idle 10 cycles -> busy = tick = done = err = 0 and count = 0 throughout.
- mode = 1, period = 3, presc = 0, start in cycle 0 -> tick in cycles 4, 7, 10, 13; busy = 1 from cycle 1; done never asserts.
- mode = 0, period = 4, presc = 2, start in cycle 0 -> single tick and done in cycle 13; busy = 1 for cycles 1..12, 0 from cycle 13; no further ticks.
- Periodic period = 5, presc = 0 started in cycle 0; stop in cycle 5 (the terminal cycle) -> no tick in cycle 6; busy = 0 and count = 0 in cycle 6.
- Periodic period = 5 started in cycle 0; restart in cycle 3 with period = 2 -> next ticks in cycles 6 and 8; no tick from the original period.
- start with period = 0 in IDLE -> err high for exactly 1 cycle, busy stays 0. Same during RUN -> err pulses and tick cadence is unchanged.
- clrn = 0 for 1 cycle mid-RUN -> the next cycle has busy = 0, count = 0, and no tick or done.

Source files
------------

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the timer controller slice.
//   state_t        : controller state (IDLE holds counters at zero, RUN counts)
//   MODE_ONESHOT   : run stops after the first elapsed period
//   MODE_PERIODIC  : run repeats the period until stopped or restarted
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_counter.sv
// ---------------------------------------------------------------------------
// timer_ctrl_counter
// Main event counter used by timer_ctrl.
//   clk     : system clock
//   aclr_n  : asynchronous active-low clear
//   sclr_n  : synchronous active-low clear (wins over en)
//   en      : count enable, increments q by one
//   q       : counter value (registered)
// ---------------------------------------------------------------------------
module timer_ctrl_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic         sclr_n,
    input  logic         en,
    output logic [W-1:0] q
);

    // Counter register: async clear, then sync clear, then increment on enable.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            q <= {W{1'b0}};
        end else if (!sclr_n) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
// Programmable prescaled timer sequencer. A host start latches mode, period
// and prescale and enters RUN; the prescaler generates one counter enable
// every presc+1 cycles and the main counter wraps after `period` enables.
//   clk    : system clock
//   clrn   : synchronous active-low reset
//   start  : start/restart request (rejected when period == 0)
//   stop   : abort request (only meaningful in RUN)
//   mode   : 0 one-shot, 1 periodic (latched on accepted start)
//   period : enables per tick, 1..2^W-1 (latched on accepted start)
//   presc  : prescale value, ratio presc+1 (latched on accepted start)
//   busy   : high while in RUN
//   tick   : 1-cycle pulse after each elapsed period
//   done   : 1-cycle pulse when a one-shot run completes
//   err    : 1-cycle pulse after a start with period == 0
//   count  : main counter value
// ---------------------------------------------------------------------------
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int W  = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [W-1:0]  period,
    input  logic [PW-1:0] presc,
    output logic          busy,
    output logic          tick,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  count
);

    state_t        state_r;
    logic          mode_l_r;
    logic [W-1:0]  period_l_r;
    logic [PW-1:0] presc_l_r;
    logic [PW-1:0] p_r;
    logic          tick_r;
    logic          done_r;
    logic          err_r;

    logic          run_s;
    logic          en_s;
    logic          terminal_s;
    logic          stop_acc_s;
    logic          start_acc_s;
    logic          start_rej_s;
    logic          cnt_clr_n_s;

    // Control decode: enable, terminal detection and request acceptance.
    always_comb begin
        run_s       = (state_r == RUN);
        en_s        = run_s && (p_r == presc_l_r);
        // period_l_r is never zero while in RUN, so the subtraction cannot wrap there.
        terminal_s  = en_s && (count == (period_l_r - {{(W-1){1'b0}}, 1'b1}));
        stop_acc_s  = stop && run_s;
        start_acc_s = start && (period != {W{1'b0}});
        start_rej_s = start && (period == {W{1'b0}});
        // The counter is cleared in IDLE, on reset, abort, restart and at wrap.
        cnt_clr_n_s = ~(~clrn | stop_acc_s | start_acc_s | terminal_s | ~run_s);
    end

    // Sequencer: state, latched configuration, prescaler and output pulses.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r    <= IDLE;
            mode_l_r   <= 1'b0;
            period_l_r <= {W{1'b0}};
            presc_l_r  <= {PW{1'b0}};
            p_r        <= {PW{1'b0}};
            tick_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= start_rej_s;
            if (stop_acc_s) begin
                // Abort wins over a coincident restart or terminal.
                state_r <= IDLE;
                p_r     <= {PW{1'b0}};
            end else if (start_acc_s) begin
                // Restart suppresses any coincident terminal.
                state_r    <= RUN;
                mode_l_r   <= mode;
                period_l_r <= period;
                presc_l_r  <= presc;
                p_r        <= {PW{1'b0}};
            end else if (run_s) begin
                if (en_s) begin
                    p_r <= {PW{1'b0}};
                end else begin
                    p_r <= p_r + {{(PW-1){1'b0}}, 1'b1};
                end
                if (terminal_s) begin
                    tick_r <= 1'b1;
                    if (mode_l_r == MODE_ONESHOT) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end else begin
                    state_r <= RUN;
                end
            end else begin
                state_r <= IDLE;
                p_r     <= {PW{1'b0}};
            end
        end
    end

    timer_ctrl_counter #(
        .W (W)
    ) u_counter (
        .clk    (clk),
        .aclr_n (1'b1),
        .sclr_n (cnt_clr_n_s),
        .en     (en_s),
        .q      (count)
    );

    assign busy = (state_r == RUN);
    assign tick = tick_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
// Self-checking bench for timer_ctrl. A reference model tracks the run in
// terms of elapsed RUN cycles since the last (re)start; the expected count
// and terminal cycle are derived from that with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int W  = 16;
    localparam int PW = 8;

    logic          clk;
    logic          clrn;
    logic          start;
    logic          stop;
    logic          mode;
    logic [W-1:0]  period;
    logic [PW-1:0] presc;
    logic          busy;
    logic          tick;
    logic          done;
    logic          err;
    logic [W-1:0]  count;

    int n_cmp;
    int n_err;

    // Reference model state.
    bit m_run;
    bit m_mode;
    int m_per;
    int m_pre;
    int m_k;
    bit e_tick;
    bit e_done;
    bit e_err;

    timer_ctrl #(
        .W  (W),
        .PW (PW)
    ) dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .period (period),
        .presc  (presc),
        .busy   (busy),
        .tick   (tick),
        .done   (done),
        .err    (err),
        .count  (count)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model and the DUT, compare outputs.
    task automatic step(input bit rn, input bit s, input bit sp, input bit md,
                        input int per, input int pr);
        bit term;
        int exp_cnt;
        clrn   = rn;
        start  = s;
        stop   = sp;
        mode   = md;
        period = per[W-1:0];
        presc  = pr[PW-1:0];

        term   = m_run && (((m_k + 1) % ((m_pre + 1) * m_per)) == 0);
        e_tick = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!rn) begin
            m_run  = 1'b0;
            m_mode = 1'b0;
            m_per  = 0;
            m_pre  = 0;
            m_k    = 0;
        end else begin
            e_err = s && (per == 0);
            if (sp && m_run) begin
                m_run = 1'b0;
                m_k   = 0;
            end else if (s && per != 0) begin
                m_run  = 1'b1;
                m_mode = md;
                m_per  = per;
                m_pre  = pr;
                m_k    = 0;
            end else if (m_run) begin
                if (term) begin
                    e_tick = 1'b1;
                    m_k    = 0;
                    if (!m_mode) begin
                        m_run  = 1'b0;
                        e_done = 1'b1;
                    end
                end else begin
                    m_k = m_k + 1;
                end
            end
        end

        @(posedge clk);
        #1;
        exp_cnt = m_run ? ((m_k / (m_pre + 1)) % m_per) : 0;
        check_val("busy",  {31'd0, busy}, {31'd0, m_run});
        check_val("tick",  {31'd0, tick}, {31'd0, e_tick});
        check_val("done",  {31'd0, done}, {31'd0, e_done});
        check_val("err",   {31'd0, err},  {31'd0, e_err});
        check_val("count", {16'd0, count}, exp_cnt);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_run  = 1'b0;
        m_mode = 1'b0;
        m_per  = 0;
        m_pre  = 0;
        m_k    = 0;
        clrn   = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 1'b0;
        period = '0;
        presc  = '0;

        // Reset then idle.
        do_reset();
        do_reset();
        for (int c = 0; c < 10; c++) idle();

        // Periodic, period 3, presc 0: ticks at cycles 4, 7, 10, 13.
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
        check_val("t2_busy1", {31'd0, busy}, 32'd1);
        for (int c = 2; c <= 14; c++) begin
            idle();
            check_val("t2_tick", {31'd0, tick},
                      {31'd0, (c == 4 || c == 7 || c == 10 || c == 13)});
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        idle();

        // One-shot, period 4, presc 2: tick and done at cycle 13 only.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4, 2);
        for (int c = 2; c <= 20; c++) begin
            idle();
            check_val("t3_done", {31'd0, done}, {31'd0, (c == 13)});
            check_val("t3_busy", {31'd0, busy}, {31'd0, (c <= 12)});
        end

        // Stop on the terminal cycle suppresses the tick.
        step(1'b1, 1'b1, 1'b0, 1'b1, 5, 0);
        for (int c = 2; c <= 5; c++) idle();
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        check_val("t4_tick", {31'd0, tick}, 32'd0);
        check_val("t4_busy", {31'd0, busy}, 32'd0);
        check_val("t4_cnt",  {16'd0, count}, 32'd0);
        idle();

        // Restart in cycle 3 with period 2: ticks at 6 and 8.
        step(1'b1, 1'b1, 1'b0, 1'b1, 5, 0);
        idle();
        idle();
        step(1'b1, 1'b1, 1'b0, 1'b1, 2, 0);
        for (int c = 5; c <= 9; c++) begin
            idle();
            check_val("t5_tick", {31'd0, tick}, {31'd0, (c == 6 || c == 8)});
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

        // Rejected start in IDLE and during RUN.
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
        check_val("t6_err", {31'd0, err}, 32'd1);
        idle();
        check_val("t6_err1", {31'd0, err}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 1);
        idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int c = 0; c < 12; c++) idle();

        // Reset for one cycle mid-run.
        do_reset();
        check_val("t7_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 3; c++) idle();

        // period 1 presc 0 periodic: tick continuously high.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            idle();
            check_val("t8_tick", {31'd0, tick}, 32'd1);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 1),
                 $urandom_range(0, 6),
                 $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
